pipe_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB), fed by the instruction decoder's per-instruction control outputs.
- Tracks the destination, write-enable and load/store class of each in-flight instruction.
- Drives stage enables, bubbles, flushes, ALU operand forwarding selects and the data-memory request handshake.
- Sits beside the datapath pipeline registers and owns all stall and flush decisions.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/fwd_unit.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and stage records for the 5-stage pipeline hazard controller.
package pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned GP_SEL_W = 2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [GP_SEL_W-1:0] GP_SRC_MEM = 2'b01;

  typedef enum logic {
    RUN  = 1'b0,
    MEMW = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] cad;
    logic             we;
    logic             is_load;
    logic             is_store;
  } ex_rec_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] cad;
    logic             we;
    logic             is_load;
    logic             is_store;
  } mem_rec_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] cad;
    logic             we;
  } wb_rec_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one EX source register; MEM result beats WB data.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_mem_valid,
  input  logic             i_mem_we,
  input  logic             i_mem_is_load,
  input  logic [REG_W-1:0] i_mem_cad,
  input  logic             i_wb_valid,
  input  logic             i_wb_we,
  input  logic [REG_W-1:0] i_wb_cad,
  output logic [1:0]       o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // A load in MEM has no ALU result worth forwarding; $0 is hardwired.
  assign w_mem_hit = i_mem_valid & i_mem_we & ~i_mem_is_load &
                     (i_mem_cad != '0) & (i_mem_cad == i_src);
  assign w_wb_hit  = i_wb_valid & i_wb_we & (i_wb_cad != '0) & (i_wb_cad == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller tracking the EX, MEM and WB occupants of a 5-stage MIPS pipe.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [REG_W-1:0]    id_cad,
  input  logic                id_gp_we,
  input  logic [GP_SEL_W-1:0] id_gp_mux_sel,
  input  logic                id_dm_we,
  input  logic                ex_redirect,
  input  logic                dmem_ack,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                idex_bubble,
  output logic                pipe_freeze,
  output logic                dmem_req,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                wb_we,
  output logic [REG_W-1:0]    wb_cad,
  output logic [CNT_W-1:0]    stall_cnt
);

  ex_rec_t          r_ex;
  mem_rec_t         r_mem;
  wb_rec_t          r_wb;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_dmem_req;
  logic       w_mem_stall;
  logic       w_hazard;
  logic       w_stall_evt;
  logic       w_pc_en;
  logic       w_ifid_en;
  logic       w_ifid_flush;
  logic       w_idex_bubble;
  logic       w_freeze;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_dmem_req  = r_mem.valid & (r_mem.is_load | r_mem.is_store);
  assign w_mem_stall = w_dmem_req & ~dmem_ack;
  assign w_hazard    = r_ex.valid & r_ex.is_load & (r_ex.cad != '0) &
                       ((id_uses_rs & (id_rs == r_ex.cad)) |
                        (id_uses_rt & (id_rt == r_ex.cad)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_mem_stall) w_state_nxt = MEMW;
      MEMW:    if (dmem_ack)    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Priority: memory stall, then redirect, then load-use, then fetch miss.
  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_freeze      = 1'b0;
    w_stall_evt   = 1'b0;
    if (w_mem_stall) begin
      w_freeze    = 1'b1;
      w_pc_en     = 1'b0;
      w_ifid_en   = 1'b0;
      w_stall_evt = 1'b1;
    end else if (ex_redirect) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_hazard) begin
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_bubble = 1'b1;
      w_stall_evt   = 1'b1;
    end else if (!if_valid) begin
      w_pc_en      = 1'b0;
      w_ifid_flush = 1'b1;
      w_stall_evt  = 1'b1;
    end
  end

  fwd_unit u_fwd_a (
    .i_src        (r_ex.rs),
    .i_mem_valid  (r_mem.valid),
    .i_mem_we     (r_mem.we),
    .i_mem_is_load(r_mem.is_load),
    .i_mem_cad    (r_mem.cad),
    .i_wb_valid   (r_wb.valid),
    .i_wb_we      (r_wb.we),
    .i_wb_cad     (r_wb.cad),
    .o_sel        (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_src        (r_ex.rt),
    .i_mem_valid  (r_mem.valid),
    .i_mem_we     (r_mem.we),
    .i_mem_is_load(r_mem.is_load),
    .i_mem_cad    (r_mem.cad),
    .i_wb_valid   (r_wb.valid),
    .i_wb_we      (r_wb.we),
    .i_wb_cad     (r_wb.cad),
    .o_sel        (w_fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!w_freeze) begin
        r_ex.valid    <= ~w_idex_bubble;
        r_ex.rs       <= id_rs;
        r_ex.rt       <= id_rt;
        r_ex.cad      <= id_cad;
        r_ex.we       <= id_gp_we;
        r_ex.is_load  <= (id_gp_mux_sel == GP_SRC_MEM);
        r_ex.is_store <= id_dm_we;
        r_mem.valid    <= r_ex.valid;
        r_mem.cad      <= r_ex.cad;
        r_mem.we       <= r_ex.we;
        r_mem.is_load  <= r_ex.is_load;
        r_mem.is_store <= r_ex.is_store;
        r_wb.valid <= r_mem.valid;
        r_wb.cad   <= r_mem.cad;
        r_wb.we    <= r_mem.we;
      end else begin
        r_wb.valid <= 1'b0;
      end
    end
  end

  // Reset forces the pipe to inject NOPs regardless of registered state.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    pipe_freeze = 1'b0;
    dmem_req    = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    wb_we       = 1'b0;
    wb_cad      = '0;
    stall_cnt   = '0;
    if (rst_n) begin
      pc_en       = w_pc_en;
      ifid_en     = w_ifid_en;
      ifid_flush  = w_ifid_flush;
      idex_bubble = w_idex_bubble;
      pipe_freeze = w_freeze;
      dmem_req    = w_dmem_req;
      fwd_a       = w_fwd_a;
      fwd_b       = w_fwd_b;
      wb_we       = r_wb.valid & r_wb.we;
      wb_cad      = r_wb.cad;
      stall_cnt   = r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             if_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_cad;
  logic             id_gp_we;
  logic [1:0]       id_gp_mux_sel;
  logic             id_dm_we;
  logic             ex_redirect;
  logic             dmem_ack;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             dmem_req;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             wb_we;
  logic [4:0]       wb_cad;
  logic [CNT_W-1:0] stall_cnt;

  int unsigned n_chk;
  int unsigned n_pass;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_cad       (id_cad),
    .id_gp_we     (id_gp_we),
    .id_gp_mux_sel(id_gp_mux_sel),
    .id_dm_we     (id_dm_we),
    .ex_redirect  (ex_redirect),
    .dmem_ack     (dmem_ack),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .pipe_freeze  (pipe_freeze),
    .dmem_req     (dmem_req),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .wb_we        (wb_we),
    .wb_cad       (wb_cad),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] cad, input logic we,
                        input logic [1:0] sel, input logic dmwe);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_cad = cad; id_gp_we = we; id_gp_mux_sel = sel; id_dm_we = dmwe;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) next_cyc();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; if_valid = 1'b1; ex_redirect = 1'b0; dmem_ack = 1'b1;
    nop();

    // Reset values
    settle();
    chk("rst_pc_en", pc_en, 0);
    chk("rst_flush", ifid_flush, 1);
    chk("rst_bubble", idex_bubble, 1);
    chk("rst_freeze", pipe_freeze, 0);
    chk("rst_cnt", stall_cnt, 0);
    next_cyc(); next_cyc();
    rst_n = 1'b1;
    settle();
    chk("run_pc_en", pc_en, 1);
    chk("run_ifid_en", ifid_en, 1);
    chk("run_flush", ifid_flush, 0);
    chk("run_fwd_a", fwd_a, 0);
    chk("run_fwd_b", fwd_b, 0);
    chk("run_cnt", stall_cnt, 0);

    // lw $5 ; add $6,$5,$7
    next_cyc();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
    next_cyc();
    set_id(5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
    settle();
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", ifid_en, 0);
    chk("lu_bubble", idex_bubble, 1);
    next_cyc(); settle();
    chk("lu2_pc_en", pc_en, 1);
    chk("lu2_bubble", idex_bubble, 0);
    chk("lu2_dmem_req", dmem_req, 1);
    chk("lu2_cnt", stall_cnt, 1);
    next_cyc();
    nop();
    settle();
    chk("lu3_fwd_a", fwd_a, 2'b10);
    chk("lu3_fwd_b", fwd_b, 2'b00);
    chk("lu3_wb_we", wb_we, 1);
    chk("lu3_wb_cad", wb_cad, 5);
    chk("lu3_cnt", stall_cnt, 1);
    drain();

    // add $3 ; sub $4,$3,$3
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00, 1'b0);
    next_cyc();
    set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 1'b0);
    next_cyc();
    nop();
    settle();
    chk("mem_fwd_a", fwd_a, 2'b01);
    chk("mem_fwd_b", fwd_b, 2'b01);
    drain();

    // add $3 ; add $3 ; sub $4,$3,$2 -> MEM beats WB on A, B from RF
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00, 1'b0);
    next_cyc();
    next_cyc();
    set_id(5'd3, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 1'b0);
    next_cyc();
    nop();
    settle();
    chk("prio_fwd_a", fwd_a, 2'b01);
    chk("prio_fwd_b", fwd_b, 2'b00);
    drain();

    // add $0 ; sub $4,$0,$0 -> never forwarded
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 2'b00, 1'b0);
    next_cyc();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 1'b0);
    next_cyc();
    nop();
    settle();
    chk("r0_fwd_a", fwd_a, 2'b00);
    chk("r0_fwd_b", fwd_b, 2'b00);
    drain();

    // sw with 3 cycles of dmem_ack low
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1);
    next_cyc();
    nop();
    next_cyc();
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sw_req", dmem_req, 1);
      chk("sw_freeze", pipe_freeze, 1);
      chk("sw_pc_en", pc_en, 0);
      if (i > 0) chk("sw_state", dut.r_state, MEMW);
      next_cyc();
    end
    dmem_ack = 1'b1;
    settle();
    chk("sw_ack_freeze", pipe_freeze, 0);
    chk("sw_ack_cnt", stall_cnt, 4);
    next_cyc(); settle();
    chk("sw_done_state", dut.r_state, RUN);
    chk("sw_done_req", dmem_req, 0);
    drain();

    // redirect coincident with load-use
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b01, 1'b0);
    next_cyc();
    set_id(5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 2'b00, 1'b0);
    ex_redirect = 1'b1;
    settle();
    chk("rd_pc_en", pc_en, 1);
    chk("rd_flush", ifid_flush, 1);
    chk("rd_bubble", idex_bubble, 1);
    next_cyc();
    ex_redirect = 1'b0;
    nop();
    settle();
    chk("rd_cnt", stall_cnt, 4);
    chk("rd_pc_en2", pc_en, 1);
    drain();

    // fetch miss
    if_valid = 1'b0;
    settle();
    chk("fm_pc_en", pc_en, 0);
    chk("fm_flush", ifid_flush, 1);
    next_cyc();
    if_valid = 1'b1;
    settle();
    chk("fm_cnt", stall_cnt, 5);

    // reset while waiting on memory
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0);
    next_cyc();
    nop();
    next_cyc();
    dmem_ack = 1'b0;
    next_cyc();
    settle();
    chk("rw_state", dut.r_state, MEMW);
    rst_n = 1'b0;
    #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_freeze", pipe_freeze, 0);
    chk("rw_pc_en", pc_en, 0);
    chk("rw_bubble", idex_bubble, 1);
    chk("rw_cnt", stall_cnt, 0);
    next_cyc();
    dmem_ack = 1'b1;
    rst_n = 1'b1;
    settle();
    chk("rw_state_run", dut.r_state, RUN);
    chk("rw_valids", {dut.r_ex.valid, dut.r_mem.valid, dut.r_wb.valid}, 0);
    chk("rw_pc_en2", pc_en, 1);
    chk("rw_req2", dmem_req, 0);

    // saturation of the narrow counter
    if_valid = 1'b0;
    for (int i = 0; i < 9; i++) next_cyc();
    if_valid = 1'b1;
    settle();
    chk("sat_cnt", stall_cnt, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
